count_digits_seq: RTL and testbench

Multi-cycle, parametrised zero-digit counter for the calculator ALU integer path. It counts zero digits of configurable radix width from the low end (trailing zeros) or the high end (leading zeros) of an operand. It scans a configurable number of digits per cycle and uses valid/ready handshakes on both sides. It feeds normalisation and digit-display logic.

---
 rtl/count_digits_pkg.sv | 21 ++
 rtl/digit_window_detect.sv | 25 ++
 rtl/count_digits_seq.sv | 119 +++++++++++
 tb/tb_count_digits_seq.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/count_digits_pkg.sv
// count_digits_pkg: shared states, mode encodings and width helpers for count_digits_seq.
package count_digits_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic MODE_LOW  = 1'b0;
  localparam logic MODE_HIGH = 1'b1;

  function automatic int ndig(input int width, input int digit_bits);
    return width / digit_bits;
  endfunction

  function automatic int cnt_w(input int width, input int digit_bits);
    return $clog2(width / digit_bits + 1);
  endfunction

  function automatic int idx_w(input int step);
    return step > 1 ? $clog2(step) : 1;
  endfunction

endpackage

// File: rtl/digit_window_detect.sv
// digit_window_detect: flags a nonzero digit in a scan-ordered window and locates the first one.
module digit_window_detect
  import count_digits_pkg::*;
#(
  parameter int DIGIT_BITS = 4,
  parameter int STEP       = 1,
  parameter int FW         = idx_w(STEP)
) (
  input  logic [STEP*DIGIT_BITS-1:0] win,
  output logic                       any_nonzero,
  output logic [FW-1:0]              first_idx
);

  // Walking downward lets the lowest (earliest in scan order) hit win.
  always_comb begin
    any_nonzero = 1'b0;
    first_idx   = '0;
    for (int j = STEP - 1; j >= 0; j--)
      if (|win[j*DIGIT_BITS +: DIGIT_BITS]) begin
        any_nonzero = 1'b1;
        first_idx   = FW'(j);
      end
  end

endmodule

// File: rtl/count_digits_seq.sv
// count_digits_seq: multi-cycle leading/trailing zero-digit counter with valid/ready handshakes.
// COUNT_DIGITS_FASTZERO_EN: zero operands skip SCAN and complete one cycle after acceptance.
module count_digits_seq
  import count_digits_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIGIT_BITS = 4,
  parameter int STEP       = 1,
  parameter int CNT_W      = cnt_w(WIDTH, DIGIT_BITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] s,
  output logic             all_zero
);

  localparam int NDIG = ndig(WIDTH, DIGIT_BITS);
  localparam int WB   = STEP * DIGIT_BITS;
  localparam int FW   = idx_w(STEP);

  state_t             state, state_n;
  logic [WIDTH-1:0]   op, op_n;
  logic               mode_q, mode_n;
  logic [CNT_W-1:0]   idx, idx_n, s_q, s_n;
  logic               az, az_n;
  logic [WB-1:0]      win;
  logic               any_nz;
  logic [FW-1:0]      first_idx;

  // The operand is shifted toward the scan end, so the window always sits at a fixed position.
  always_comb begin
    win = '0;
    for (int j = 0; j < STEP; j++)
      win[j*DIGIT_BITS +: DIGIT_BITS] = mode_q == MODE_HIGH ? op[WIDTH-(j+1)*DIGIT_BITS +: DIGIT_BITS]
                                                            : op[j*DIGIT_BITS +: DIGIT_BITS];
  end

  digit_window_detect #(
    .DIGIT_BITS (DIGIT_BITS),
    .STEP       (STEP),
    .FW         (FW)
  ) u_detect (
    .win         (win),
    .any_nonzero (any_nz),
    .first_idx   (first_idx)
  );

  always_comb begin
    state_n = state;
    op_n    = op;
    mode_n  = mode_q;
    idx_n   = idx;
    s_n     = s_q;
    az_n    = az;
    unique case (state)
      IDLE: if (in_valid) begin
        op_n    = a;
        mode_n  = mode;
        idx_n   = '0;
        s_n     = '0;
        az_n    = 1'b0;
        state_n = SCAN;
`ifdef COUNT_DIGITS_FASTZERO_EN
        if (a == '0) begin
          s_n     = CNT_W'(NDIG);
          az_n    = 1'b1;
          state_n = DONE;
        end
`else
`endif
      end
      SCAN: if (any_nz) begin
        s_n     = idx + CNT_W'(first_idx);
        az_n    = 1'b0;
        state_n = DONE;
      end else begin
        op_n  = mode_q == MODE_HIGH ? op << WB : op >> WB;
        idx_n = idx + CNT_W'(STEP);
        if (idx_n == CNT_W'(NDIG)) begin
          s_n     = CNT_W'(NDIG);
          az_n    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op     <= '0;
      mode_q <= MODE_LOW;
      idx    <= '0;
      s_q    <= '0;
      az     <= 1'b0;
    end else begin
      state  <= state_n;
      op     <= op_n;
      mode_q <= mode_n;
      idx    <= idx_n;
      s_q    <= s_n;
      az     <= az_n;
    end
  end

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign s         = s_q;
  assign all_zero  = az;

endmodule

// File: tb/tb_count_digits_seq.sv
// tb_count_digits_seq: directed vector table plus handshake, backpressure and reset corner cases.
module tb_count_digits_seq;

`ifdef COUNT_DIGITS_FASTZERO_EN
  localparam int ZL1 = 0;
  localparam int ZL2 = 0;
`else
  localparam int ZL1 = 8;
  localparam int ZL2 = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv1 = 1'b0, ir1, m1 = 1'b0, ov1, or1 = 1'b0, az1;
  logic [31:0] a1 = '0;
  logic [3:0]  s1;
  logic        iv2 = 1'b0, ir2, m2 = 1'b0, ov2, or2 = 1'b0, az2;
  logic [31:0] a2 = '0;
  logic [5:0]  s2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  count_digits_seq #(.WIDTH(32), .DIGIT_BITS(4), .STEP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .mode(m1),
    .out_valid(ov1), .out_ready(or1), .s(s1), .all_zero(az1)
  );

  count_digits_seq #(.WIDTH(32), .DIGIT_BITS(1), .STEP(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .mode(m2),
    .out_valid(ov2), .out_ready(or2), .s(s2), .all_zero(az2)
  );

  typedef struct {
    logic [31:0] a;
    logic        mode;
    int          s;
    logic        az;
    int          lat;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run1(input string nm, input logic [31:0] av, input logic mv,
                      input int es, input logic eaz, input int el);
    int n;
    @(negedge clk); iv1 = 1'b1; a1 = av; m1 = mv;
    @(posedge clk); #1; iv1 = 1'b0; a1 = $urandom; m1 = ~mv; n = 0;
    while (!ov1 && n < 200) begin @(posedge clk); #1; n++; end
    chk({nm, " lat"}, n, el);
    chk({nm, " s"}, int'(s1), es);
    chk({nm, " all_zero"}, int'(az1), int'(eaz));
    @(negedge clk); or1 = 1'b1;
    @(posedge clk); #1; or1 = 1'b0;
    chk({nm, " in_ready"}, int'(ir1), 1);
  endtask

  task automatic run2(input string nm, input logic [31:0] av, input logic mv,
                      input int es, input logic eaz, input int el);
    int n;
    @(negedge clk); iv2 = 1'b1; a2 = av; m2 = mv;
    @(posedge clk); #1; iv2 = 1'b0; a2 = $urandom; m2 = ~mv; n = 0;
    while (!ov2 && n < 200) begin @(posedge clk); #1; n++; end
    chk({nm, " lat"}, n, el);
    chk({nm, " s"}, int'(s2), es);
    chk({nm, " all_zero"}, int'(az2), int'(eaz));
    @(negedge clk); or2 = 1'b1;
    @(posedge clk); #1; or2 = 1'b0;
    chk({nm, " in_ready"}, int'(ir2), 1);
  endtask

  initial begin
    int n;
    vt[0] = '{32'h0000_1000, 1'b0, 3, 1'b0, 4};
    vt[1] = '{32'h0000_1000, 1'b1, 4, 1'b0, 5};
    vt[2] = '{32'h0000_0000, 1'b0, 8, 1'b1, ZL1};
    vt[3] = '{32'h0000_0000, 1'b1, 8, 1'b1, ZL1};
    vt[4] = '{32'h8000_0000, 1'b0, 7, 1'b0, 8};
    vt[5] = '{32'h8000_0000, 1'b1, 0, 1'b0, 1};
    vt[6] = '{32'h0000_0001, 1'b0, 0, 1'b0, 1};
    vt[7] = '{32'h0000_0001, 1'b1, 7, 1'b0, 8};
    vt[8] = '{32'h0F00_0000, 1'b1, 1, 1'b0, 2};
    vt[9] = '{32'h0F00_0000, 1'b0, 6, 1'b0, 7};

    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", int'(ir1), 1);
    chk("reset out_valid", int'(ov1), 0);
    chk("reset s", int'(s1), 0);
    chk("reset all_zero", int'(az1), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run1($sformatf("vec%0d", i), vt[i].a, vt[i].mode, vt[i].s, vt[i].az, vt[i].lat);

    run2("bin low", 32'h0000_1000, 1'b0, 12, 1'b0, 7);
    run2("bin high", 32'h0000_1000, 1'b1, 19, 1'b0, 10);
    run2("bin zero", 32'h0000_0000, 1'b0, 32, 1'b1, ZL2);

    @(negedge clk); iv1 = 1'b1; a1 = 32'h0000_1000; m1 = 1'b0;
    @(posedge clk); #1; iv1 = 1'b0; n = 0;
    while (!ov1 && n < 200) begin @(posedge clk); #1; n++; end
    chk("bp lat", n, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); iv1 = 1'(i % 2 == 0); a1 = $urandom | 32'h1; m1 = 1'(i % 2);
      @(posedge clk); #1;
      chk("bp s", int'(s1), 3);
      chk("bp in_ready", int'(ir1), 0);
      chk("bp out_valid", int'(ov1), 1);
    end
    @(negedge clk); or1 = 1'b1; iv1 = 1'b1; a1 = 32'h0000_0001; m1 = 1'b1;
    @(posedge clk); #1; or1 = 1'b0;
    chk("bp release in_ready", int'(ir1), 1);
    chk("bp release out_valid", int'(ov1), 0);
    @(posedge clk); #1; iv1 = 1'b0;
    chk("bp next accept", int'(ir1), 0);
    n = 0;
    while (!ov1 && n < 200) begin @(posedge clk); #1; n++; end
    chk("bp next lat", n, 8);
    chk("bp next s", int'(s1), 7);
    @(negedge clk); or1 = 1'b1;
    @(posedge clk); #1; or1 = 1'b0;

    @(negedge clk); iv1 = 1'b1; a1 = 32'h8000_0000; m1 = 1'b0;
    @(posedge clk); #1; iv1 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst mid in_ready", int'(ir1), 1);
    chk("rst mid out_valid", int'(ov1), 0);
    chk("rst mid s", int'(s1), 0);
    chk("rst mid all_zero", int'(az1), 0);
    rst_n = 1'b1;
    run1("post rst", 32'h0000_1000, 1'b1, 4, 1'b0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
